// File: rtl/cselector_n_pmp.sv
// N-way token selector/fork for the PMP check path.
// One upstream token (payload + select mask) is latched and offered to every
// selected downstream channel (broadcast) or to the lowest selected channel
// only (priority). Upstream is freed once all selected channels have taken it.
// Tokens whose effective mask is empty are dropped and counted (saturating).
//
// state | meaning
// IDLE  | no token held; o_free high (outside reset), accepting a new token
// BUSY  | token held in r_data; o_driveNext shows channels still to accept
module cselector_n_pmp #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int MODE   = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_drive,
    output logic              o_free,
    input  logic [DATA_W-1:0] i_data,
    input  logic [N-1:0]      i_sel,
    output logic [N-1:0]      o_driveNext,
    input  logic [N-1:0]      i_freeNext,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_drop_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [N-1:0]        r_pending;
    logic [DATA_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic [N-1:0]        w_one;
    logic [N-1:0]        w_mask;
    logic [N-1:0]        w_remain;
    logic                w_accept;
    logic [CNT_W-1:0]    w_cnt_max;

    assign w_one     = {{(N-1){1'b0}}, 1'b1};
    assign w_cnt_max = {CNT_W{1'b1}};

    // Effective mask: raw select in broadcast mode, lowest set bit in priority mode
    always_comb begin
        w_mask = i_sel;
        if (MODE == 1) begin
            w_mask = i_sel & (~i_sel + w_one);
        end
    end

    assign w_accept = (r_state == ST_IDLE) & i_drive & ~rstn;
    // Ready bits of channels not pending are masked off here, so they are ignored
    assign w_remain = r_pending & ~i_freeNext;

    // Token FSM: latch on accept, retire channels as they accept, count drops
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_data     <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data <= i_data;
                        if (w_mask != '0) begin
                            r_pending <= w_mask;
                            r_state   <= ST_BUSY;
                        end else if (r_drop_cnt != w_cnt_max) begin
                            r_drop_cnt <= r_drop_cnt + 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    r_pending <= w_remain;
                    if (w_remain == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pending <= '0;
                end
            endcase
        end
    end

    // Outputs depend only on registers and reset, never on i_freeNext
    assign o_free      = (r_state == ST_IDLE) & ~rstn;
    assign o_busy      = (r_state == ST_BUSY);
    assign o_driveNext = (r_state == ST_BUSY) ? r_pending : '0;
    assign o_data      = r_data;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_cselector_n_pmp.sv
// Directed bench for cselector_n_pmp: broadcast, priority and small-counter
// instances share clock and reset; each has its own stimulus.
module tb_cselector_n_pmp;

    logic clk;
    logic rstn;

    // broadcast instance (MODE=0, CNT_W=8)
    logic        a_drive, a_free, a_busy;
    logic [31:0] a_data_i, a_data_o;
    logic [3:0]  a_sel, a_dn, a_fn;
    logic [7:0]  a_cnt;

    // priority instance (MODE=1)
    logic        b_drive, b_free, b_busy;
    logic [31:0] b_data_i, b_data_o;
    logic [3:0]  b_sel, b_dn, b_fn;
    logic [7:0]  b_cnt;

    // small drop counter instance (CNT_W=2)
    logic        c_drive, c_free, c_busy;
    logic [31:0] c_data_i, c_data_o;
    logic [3:0]  c_sel, c_dn, c_fn;
    logic [1:0]  c_cnt;

    int n_checks;
    int n_errors;

    cselector_n_pmp #(.N(4), .DATA_W(32), .MODE(0), .CNT_W(8)) u_dut_a (
        .clk(clk), .rstn(rstn), .i_drive(a_drive), .o_free(a_free),
        .i_data(a_data_i), .i_sel(a_sel), .o_driveNext(a_dn),
        .i_freeNext(a_fn), .o_data(a_data_o), .o_busy(a_busy),
        .o_drop_cnt(a_cnt)
    );

    cselector_n_pmp #(.N(4), .DATA_W(32), .MODE(1), .CNT_W(8)) u_dut_b (
        .clk(clk), .rstn(rstn), .i_drive(b_drive), .o_free(b_free),
        .i_data(b_data_i), .i_sel(b_sel), .o_driveNext(b_dn),
        .i_freeNext(b_fn), .o_data(b_data_o), .o_busy(b_busy),
        .o_drop_cnt(b_cnt)
    );

    cselector_n_pmp #(.N(4), .DATA_W(32), .MODE(0), .CNT_W(2)) u_dut_c (
        .clk(clk), .rstn(rstn), .i_drive(c_drive), .o_free(c_free),
        .i_data(c_data_i), .i_sel(c_sel), .o_driveNext(c_dn),
        .i_freeNext(c_fn), .o_data(c_data_o), .o_busy(c_busy),
        .o_drop_cnt(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rstn = 1'b1;
        a_drive = 1'b1; a_data_i = 32'h0; a_sel = 4'h0; a_fn = 4'h0;
        b_drive = 1'b0; b_data_i = 32'h0; b_sel = 4'h0; b_fn = 4'h0;
        c_drive = 1'b0; c_data_i = 32'h0; c_sel = 4'h0; c_fn = 4'h0;

        // 1. reset held 3 cycles with drive asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_free",  a_free, 0);
            check("rst_dn",    a_dn,   0);
            check("rst_cnt",   a_cnt,  0);
            check("rst_busy",  a_busy, 0);
        end
        check("rst_data", a_data_o, 0);
        rstn = 1'b0;
        a_drive = 1'b0;
        tick();
        check("rel_free", a_free, 1);
        check("rel_dn",   a_dn,   0);

        // 2. broadcast to channels 1 and 3, ch1 ready first cycle, ch3 three cycles later
        a_drive = 1'b1; a_sel = 4'b1010; a_data_i = 32'hA5A5_0001; a_fn = 4'b0000;
        tick();
        a_drive = 1'b0; a_data_i = 32'hDEAD_BEEF; a_sel = 4'b0101;
        check("bc_dn0",   a_dn,     4'b1010);
        check("bc_free0", a_free,   0);
        check("bc_data0", a_data_o, 32'hA5A5_0001);
        a_fn = 4'b0010;
        tick();
        a_fn = 4'b0000;
        check("bc_dn1",   a_dn,     4'b1000);
        check("bc_data1", a_data_o, 32'hA5A5_0001);
        tick();
        check("bc_dn2",   a_dn,     4'b1000);
        check("bc_free2", a_free,   0);
        tick();
        check("bc_dn3",   a_dn,     4'b1000);
        check("bc_data3", a_data_o, 32'hA5A5_0001);
        a_fn = 4'b1000;
        tick();
        a_fn = 4'b0000;
        check("bc_dn4",   a_dn,   4'b0000);
        check("bc_free4", a_free, 1);
        check("bc_busy4", a_busy, 0);

        // 3. priority mode picks lowest of 1100; ready on ch3 is ignored
        b_drive = 1'b1; b_sel = 4'b1100; b_data_i = 32'h0000_0333;
        tick();
        b_drive = 1'b0;
        check("pr_dn0", b_dn, 4'b0100);
        b_fn = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pr_hold_dn",   b_dn,   4'b0100);
            check("pr_hold_busy", b_busy, 1);
        end
        b_fn = 4'b0100;
        tick();
        b_fn = 4'b0000;
        check("pr_done_dn",   b_dn,   4'b0000);
        check("pr_done_free", b_free, 1);
        check("pr_cnt",       b_cnt,  0);

        // 4. all channels ready: 1-cycle BUSY, tokens every 2 cycles
        a_drive = 1'b1; a_sel = 4'b1111; a_fn = 4'b1111; a_data_i = 32'h0000_1000;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("sim_busy", a_busy, 1);
            check("sim_dn",   a_dn,   4'b1111);
            check("sim_data", a_data_o, 32'h0000_1000 + t);
            a_data_i = 32'h0000_1001 + t;
            tick();
            check("sim_idle", a_busy, 0);
            check("sim_free", a_free, 1);
        end
        a_drive = 1'b0; a_fn = 4'b0000; a_sel = 4'b0000;

        // 5. zero-mask drops
        a_drive = 1'b1; a_sel = 4'b0000;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("drop_free", a_free, 1);
            check("drop_dn",   a_dn,   0);
            check("drop_cnt",  a_cnt,  i);
        end
        a_drive = 1'b0;
        c_drive = 1'b1; c_sel = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("sat_cnt",  c_cnt,  (i > 3) ? 3 : i);
            check("sat_free", c_free, 1);
        end
        c_drive = 1'b0;

        // 6. reset in the second BUSY cycle
        a_drive = 1'b1; a_sel = 4'b0011; a_fn = 4'b0000; a_data_i = 32'h0000_0066;
        tick();
        a_drive = 1'b0;
        check("mr_dn0", a_dn, 4'b0011);
        tick();
        check("mr_dn1", a_dn, 4'b0011);
        rstn = 1'b1;
        tick();
        check("mr_dn_rst",   a_dn,   0);
        check("mr_busy_rst", a_busy, 0);
        check("mr_free_rst", a_free, 0);
        check("mr_cnt_rst",  a_cnt,  0);
        rstn = 1'b0;
        tick();
        check("mr_dn_after",   a_dn,   0);
        check("mr_free_after", a_free, 1);
        a_drive = 1'b1; a_sel = 4'b0001; a_fn = 4'b0001; a_data_i = 32'h0000_0077;
        tick();
        a_drive = 1'b0;
        check("mr_new_dn",   a_dn,     4'b0001);
        check("mr_new_data", a_data_o, 32'h0000_0077);
        tick();
        a_fn = 4'b0000;
        check("mr_new_done", a_free, 1);
        check("mr_new_dn2",  a_dn,   0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
